// File: rtl/rank_order_encoder.sv
// -----------------------------------------------------------------------------
// rank_order_encoder
//
// Purpose:
//   Buffers one multi-channel image streamed over a valid/ready port. It then
//   replays the pixels as AER events in descending-intensity order over a
//   four-phase REQ/ACK link. Ties are emitted in ascending channel, then
//   ascending pixel order.
//   Features:
//     - Pixels below a runtime threshold are never emitted.
//     - An optional event cap truncates the stream (k-winner).
//     - Each scan pass also finds the next lower occupied level, so empty
//       intensity levels cost no passes.
//
// Ports:
//   CLK             rising-edge clock
//   RST             asynchronous active-low reset
//   NEW_IMAGE       start pulse, accepted only in IDLE
//   THRESHOLD       minimum emitted value, latched on accepted NEW_IMAGE
//   MAX_EVENTS      event cap (0 = unlimited), latched on accepted NEW_IMAGE
//   PIX_DATA        streamed pixel
//   PIX_VALID       PIX_DATA valid
//   PIX_READY       high while loading
//   INFERENCE_DONE  abort request
//   IMAGE_ENCODED   one-cycle completion pulse
//   BUSY            high in every state except IDLE
//   EVENT_COUNT     events emitted for the current image
//   AERIN_ADDR      {channel[1:0], pixel_id}
//   AERIN_REQ       AER request
//   AERIN_ACK       AER acknowledge
// -----------------------------------------------------------------------------
module rank_order_encoder #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = 8,
  parameter int PIXEL_W         = 8,
  parameter int CHANNELS        = 1,
  parameter int CNT_W           = IMAGE_SIZE_BITS + 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       NEW_IMAGE,
  input  logic [PIXEL_W-1:0]         THRESHOLD,
  input  logic [CNT_W-1:0]           MAX_EVENTS,
  input  logic [PIXEL_W-1:0]         PIX_DATA,
  input  logic                       PIX_VALID,
  output logic                       PIX_READY,
  input  logic                       INFERENCE_DONE,
  output logic                       IMAGE_ENCODED,
  output logic                       BUSY,
  output logic [CNT_W-1:0]           EVENT_COUNT,
  output logic [IMAGE_SIZE_BITS+1:0] AERIN_ADDR,
  output logic                       AERIN_REQ,
  input  logic                       AERIN_ACK
);

  localparam int TOTAL  = CHANNELS * IMAGE_SIZE;
  localparam int IDX_W  = IMAGE_SIZE_BITS + 2;
  localparam int MEM_AW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_REQ,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [PIXEL_W-1:0]     r_mem [TOTAL];
  logic [IDX_W-1:0]       r_idx;
  logic [PIXEL_W-1:0]     r_thr;
  logic [CNT_W-1:0]       r_max_events;
  logic [PIXEL_W-1:0]     r_max;
  logic [PIXEL_W-1:0]     r_level;
  logic [PIXEL_W-1:0]     r_next_max;
  logic                   r_next_valid;
  logic                   r_abort;
  logic                   r_pix_ready;
  logic                   r_req;
  logic [IDX_W-1:0]       r_addr;
  logic                   r_encoded;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_count;

  logic                   w_beat;
  logic                   w_last;
  logic [PIXEL_W-1:0]     w_pix;
  logic [PIXEL_W-1:0]     w_load_max;
  logic                   w_cand;
  logic                   w_nv;
  logic [PIXEL_W-1:0]     w_nmax;
  logic                   w_cap_hit;

  // Pixel storage has no reset; its contents are only meaningful after a load.
  always_ff @(posedge CLK) begin
    if (w_beat) begin
      r_mem[r_idx[MEM_AW-1:0]] <= PIX_DATA;
    end
  end

  assign w_beat     = (r_state == S_LOAD) && PIX_VALID && r_pix_ready;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_pix      = r_mem[r_idx[MEM_AW-1:0]];
  assign w_load_max = (PIX_DATA > r_max) ? PIX_DATA : r_max;

  // Candidate for the next (lower) level: the value must be at or above the
  // threshold and below the current level. It must also beat what this pass
  // has found so far. The valid flag lets a level equal to the cleared
  // next_max value still be recorded.
  assign w_cand = (w_pix >= r_thr) && (w_pix < r_level) &&
                  (!r_next_valid || (w_pix > r_next_max));
  assign w_nv   = r_next_valid | w_cand;
  assign w_nmax = w_cand ? w_pix : r_next_max;

  assign w_cap_hit = (r_max_events != '0) && (r_count == r_max_events);

  // Main controller. All outputs are registered here. IMAGE_ENCODED defaults
  // low each cycle and is raised only on the transition into DONE, which
  // makes it a single-cycle pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_thr        <= '0;
      r_max_events <= '0;
      r_max        <= '0;
      r_level      <= '0;
      r_next_max   <= '0;
      r_next_valid <= 1'b0;
      r_abort      <= 1'b0;
      r_pix_ready  <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_encoded    <= 1'b0;
      r_busy       <= 1'b0;
      r_count      <= '0;
    end else begin
      r_encoded <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (NEW_IMAGE) begin
            r_state      <= S_LOAD;
            r_thr        <= THRESHOLD;
            r_max_events <= MAX_EVENTS;
            r_count      <= '0;
            r_idx        <= '0;
            r_max        <= '0;
            r_next_max   <= '0;
            r_next_valid <= 1'b0;
            r_abort      <= 1'b0;
            r_pix_ready  <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        S_LOAD: begin
          if (INFERENCE_DONE) begin
            r_pix_ready <= 1'b0;
            r_state     <= S_DONE;
            r_encoded   <= 1'b1;
          end else if (w_beat) begin
            r_max <= w_load_max;
            if (w_last) begin
              r_pix_ready <= 1'b0;
              // The running max including this final beat seeds the first
              // scan level; nothing at or above threshold means no events.
              if (w_load_max >= r_thr) begin
                r_state <= S_SCAN;
                r_level <= w_load_max;
                r_idx   <= '0;
              end else begin
                r_state   <= S_DONE;
                r_encoded <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        S_SCAN: begin
          if (INFERENCE_DONE) begin
            r_state   <= S_DONE;
            r_encoded <= 1'b1;
          end else if (w_pix == r_level) begin
            // Channel-major storage makes the index equal to {channel, pixel}.
            r_addr  <= r_idx;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else if (w_last) begin
            if (w_nv) begin
              r_level      <= w_nmax;
              r_next_max   <= '0;
              r_next_valid <= 1'b0;
              r_idx        <= '0;
            end else begin
              r_state   <= S_DONE;
              r_encoded <= 1'b1;
            end
          end else begin
            r_next_max   <= w_nmax;
            r_next_valid <= w_nv;
            r_idx        <= r_idx + IDX_W'(1);
          end
        end

        S_REQ: begin
          // An abort here is only remembered; REQ stays up until ACK.
          if (INFERENCE_DONE) begin
            r_abort <= 1'b1;
          end
          if (AERIN_ACK) begin
            r_req   <= 1'b0;
            r_count <= r_count + CNT_W'(1);
            r_state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          if (INFERENCE_DONE) begin
            r_abort <= 1'b1;
          end
          if (!AERIN_ACK) begin
            if (w_cap_hit || r_abort || INFERENCE_DONE) begin
              r_state   <= S_DONE;
              r_encoded <= 1'b1;
            end else if (w_last) begin
              // The emitted pixel equals the level, so it never contributes
              // to next_max; the pass result is already complete.
              if (r_next_valid) begin
                r_level      <= r_next_max;
                r_next_max   <= '0;
                r_next_valid <= 1'b0;
                r_idx        <= '0;
                r_state      <= S_SCAN;
              end else begin
                r_state   <= S_DONE;
                r_encoded <= 1'b1;
              end
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_SCAN;
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_req       <= 1'b0;
          r_pix_ready <= 1'b0;
        end
      endcase
    end
  end

  assign PIX_READY     = r_pix_ready;
  assign IMAGE_ENCODED = r_encoded;
  assign BUSY          = r_busy;
  assign EVENT_COUNT   = r_count;
  assign AERIN_ADDR    = r_addr;
  assign AERIN_REQ     = r_req;

endmodule

// File: tb/tb_rank_order_encoder.sv
// -----------------------------------------------------------------------------
// tb_rank_order_encoder
//
// Purpose:
//   Self-checking bench for rank_order_encoder, configured with IMAGE_SIZE=4
//   and CHANNELS=2. It applies a table of hand-derived vectors, a
//   reset-during-handshake sequence, and randomized images against a
//   level-by-level reference model.
// -----------------------------------------------------------------------------
module tb_rank_order_encoder;

  localparam int IS  = 4;
  localparam int ISB = 2;
  localparam int PW  = 8;
  localparam int CH  = 2;
  localparam int CW  = ISB + 3;
  localparam int TOT = CH * IS;
  localparam int NVEC = 7;

  typedef logic [TOT-1:0][PW-1:0] img_t;
  typedef logic [TOT-1:0][ISB+1:0] exp_t;

  typedef struct packed {
    img_t            pix;
    logic [PW-1:0]   thr;
    logic [CW-1:0]   maxev;
    int              abortAt;
    int              expN;
    exp_t            expAddr;
    int              expFirstReq;
    int              expEncIter;
  } vec_t;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            NEW_IMAGE = 1'b0;
  logic [PW-1:0]   THRESHOLD = '0;
  logic [CW-1:0]   MAX_EVENTS = '0;
  logic [PW-1:0]   PIX_DATA = '0;
  logic            PIX_VALID = 1'b0;
  logic            PIX_READY;
  logic            INFERENCE_DONE = 1'b0;
  logic            IMAGE_ENCODED;
  logic            BUSY;
  logic [CW-1:0]   EVENT_COUNT;
  logic [ISB+1:0]  AERIN_ADDR;
  logic            AERIN_REQ;
  logic            AERIN_ACK = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int gotQ[$];
  int expQ[$];
  int firstReq;
  int encIter;
  vec_t vecs[NVEC];

  rank_order_encoder #(
    .IMAGE_SIZE(IS),
    .IMAGE_SIZE_BITS(ISB),
    .PIXEL_W(PW),
    .CHANNELS(CH),
    .CNT_W(CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .NEW_IMAGE(NEW_IMAGE),
    .THRESHOLD(THRESHOLD),
    .MAX_EVENTS(MAX_EVENTS),
    .PIX_DATA(PIX_DATA),
    .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY),
    .INFERENCE_DONE(INFERENCE_DONE),
    .IMAGE_ENCODED(IMAGE_ENCODED),
    .BUSY(BUSY),
    .EVENT_COUNT(EVENT_COUNT),
    .AERIN_ADDR(AERIN_ADDR),
    .AERIN_REQ(AERIN_REQ),
    .AERIN_ACK(AERIN_ACK)
  );

  always #5 CLK = ~CLK;

  // Stops a hung run while still reporting it.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  function automatic img_t mkImg(input int a0, input int a1, input int a2, input int a3,
                                 input int a4, input int a5, input int a6, input int a7);
    img_t r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
    return r;
  endfunction

  function automatic exp_t mkExp(input int e0, input int e1, input int e2, input int e3);
    exp_t r;
    r = '0;
    r[0] = 4'(e0); r[1] = 4'(e1); r[2] = 4'(e2); r[3] = 4'(e3);
    return r;
  endfunction

  function automatic vec_t mkVec(input img_t p, input int thr, input int maxev, input int abortAt,
                                 input int expN, input exp_t e, input int fr, input int ei);
    vec_t v;
    v.pix = p;
    v.thr = 8'(thr);
    v.maxev = CW'(maxev);
    v.abortAt = abortAt;
    v.expN = expN;
    v.expAddr = e;
    v.expFirstReq = fr;
    v.expEncIter = ei;
    return v;
  endfunction

  // Reference: walk every intensity from the top down to the threshold and
  // list matching pixels in storage order, then apply cap and abort cut-offs.
  function automatic void refModel(input img_t pix, input int thr, input int maxev, input int abortAt);
    expQ.delete();
    for (int lvl = 255; lvl >= thr; lvl--) begin
      for (int i = 0; i < TOT; i++) begin
        if (int'(pix[i]) == lvl) expQ.push_back(i);
      end
    end
    if (maxev != 0) begin
      while (expQ.size() > maxev) void'(expQ.pop_back());
    end
    if (abortAt >= 0) begin
      while (expQ.size() > abortAt + 1) void'(expQ.pop_back());
    end
  endfunction

  task automatic startAndLoad(input img_t pix, input logic [PW-1:0] thr, input logic [CW-1:0] maxev);
    @(negedge CLK);
    NEW_IMAGE  = 1'b1;
    THRESHOLD  = thr;
    MAX_EVENTS = maxev;
    @(negedge CLK);
    NEW_IMAGE  = 1'b0;
    THRESHOLD  = 8'($urandom);
    MAX_EVENTS = CW'($urandom);
    checkOutput("readyRise", int'(PIX_READY), 1);
    checkOutput("busyRise", int'(BUSY), 1);
    checkOutput("countClear", int'(EVENT_COUNT), 0);
    for (int i = 0; i < TOT; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        PIX_VALID = 1'b0;
        @(negedge CLK);
      end
      PIX_VALID = 1'b1;
      PIX_DATA  = pix[i];
      @(negedge CLK);
    end
    PIX_VALID = 1'b0;
    checkOutput("readyDrop", int'(PIX_READY), 0);
  endtask

  task automatic applyStimulus(input img_t pix, input logic [PW-1:0] thr,
                               input logic [CW-1:0] maxev, input int abortAt);
    int  it;
    int  delay;
    bit  done;
    bit  inReq;
    int  reqAddr;
    gotQ.delete();
    firstReq = -1;
    encIter  = -1;
    startAndLoad(pix, thr, maxev);
    it = 0; done = 0; inReq = 0; delay = 0; reqAddr = 0;
    while (!done && it < 3000) begin
      INFERENCE_DONE = 1'b0;
      NEW_IMAGE      = 1'b0;
      if (IMAGE_ENCODED) begin
        encIter   = it;
        done      = 1;
        NEW_IMAGE = 1'b1;
      end else if (AERIN_ACK) begin
        checkOutput("reqDrop", int'(AERIN_REQ), 0);
        AERIN_ACK = 1'b0;
      end else if (AERIN_REQ) begin
        if (!inReq) begin
          inReq   = 1;
          reqAddr = int'(AERIN_ADDR);
          delay   = $urandom_range(0, 3);
          if (firstReq < 0) firstReq = it;
          if (gotQ.size() == abortAt) begin
            INFERENCE_DONE = 1'b1;
            NEW_IMAGE      = 1'b1;
          end
        end else begin
          checkOutput("addrStable", int'(AERIN_ADDR), reqAddr);
        end
        if (delay == 0) begin
          gotQ.push_back(int'(AERIN_ADDR));
          AERIN_ACK = 1'b1;
          inReq = 0;
        end else begin
          delay--;
        end
      end
      @(negedge CLK);
      it++;
    end
    NEW_IMAGE      = 1'b0;
    INFERENCE_DONE = 1'b0;
    AERIN_ACK      = 1'b0;
    checkOutput("encodedSeen", int'(done), 1);
    checkOutput("encPulse", int'(IMAGE_ENCODED), 0);
    checkOutput("busyIdle", int'(BUSY), 0);
    @(negedge CLK);
    checkOutput("newImageIgnored", int'(BUSY), 0);
  endtask

  task automatic checkRun(input string tag);
    checkOutput({tag, "_events"}, gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), gotQ[i], expQ[i]);
    end
    checkOutput({tag, "_eventCount"}, int'(EVENT_COUNT), expQ.size());
  endtask

  task automatic waitReq(output bit ok);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (AERIN_REQ) ok = 1;
      else @(negedge CLK);
    end
  endtask

  initial begin
    img_t ordImg;
    img_t rimg;
    bit   ok;
    int   thr;
    int   mx;
    int   ab;

    ordImg = mkImg(10, 200, 10, 0, 0, 0, 0, 0);
    vecs[0] = mkVec(ordImg, 1, 0, -1, 3, mkExp(1, 0, 2, 0), 2, -1);
    vecs[1] = mkVec(ordImg, 1, 2, -1, 2, mkExp(1, 0, 0, 0), 2, -1);
    vecs[2] = mkVec(mkImg(5, 0, 0, 0, 0, 9, 5, 0), 1, 0, -1, 3, mkExp(5, 0, 6, 0), 6, -1);
    vecs[3] = mkVec(mkImg(10, 49, 0, 3, 20, 30, 40, 1), 50, 0, -1, 0, mkExp(0, 0, 0, 0), -1, 0);
    vecs[4] = mkVec(ordImg, 1, 0, 0, 1, mkExp(1, 0, 0, 0), 2, -1);
    vecs[5] = mkVec(mkImg(50, 49, 50, 51, 0, 0, 0, 0), 50, 0, -1, 3, mkExp(3, 0, 2, 0), 4, -1);
    vecs[6] = mkVec(ordImg, 1, 3, -1, 3, mkExp(1, 0, 2, 0), 2, -1);

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_pixReady", int'(PIX_READY), 0);
    checkOutput("rst_req", int'(AERIN_REQ), 0);
    checkOutput("rst_addr", int'(AERIN_ADDR), 0);
    checkOutput("rst_encoded", int'(IMAGE_ENCODED), 0);
    checkOutput("rst_busy", int'(BUSY), 0);
    checkOutput("rst_count", int'(EVENT_COUNT), 0);
    RST = 1'b1;
    @(negedge CLK);

    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].pix, vecs[v].thr, vecs[v].maxev, vecs[v].abortAt);
      expQ.delete();
      for (int i = 0; i < vecs[v].expN; i++) expQ.push_back(int'(vecs[v].expAddr[i]));
      checkRun($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_firstReqLatency", v), firstReq, vecs[v].expFirstReq);
      if (vecs[v].expEncIter >= 0) begin
        checkOutput($sformatf("vec%0d_encLatency", v), encIter, vecs[v].expEncIter);
      end
    end

    // Reset asserted while the second event is being requested.
    startAndLoad(ordImg, 8'd1, '0);
    waitReq(ok);
    checkOutput("rstMid_req1", int'(ok), 1);
    AERIN_ACK = 1'b1;
    @(negedge CLK);
    AERIN_ACK = 1'b0;
    @(negedge CLK);
    waitReq(ok);
    checkOutput("rstMid_req2", int'(ok), 1);
    checkOutput("rstMid_countBefore", int'(EVENT_COUNT), 1);
    #2 RST = 1'b0;
    #1;
    checkOutput("rstMid_req", int'(AERIN_REQ), 0);
    checkOutput("rstMid_busy", int'(BUSY), 0);
    checkOutput("rstMid_count", int'(EVENT_COUNT), 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    applyStimulus(ordImg, 8'd1, '0, -1);
    refModel(ordImg, 1, 0, -1);
    checkRun("afterRst");

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < TOT; i++) rimg[i] = 8'($urandom_range(0, 6) * 40);
      thr = $urandom_range(1, 250);
      mx  = $urandom_range(0, 6);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
      applyStimulus(rimg, 8'(thr), CW'(mx), ab);
      refModel(rimg, thr, mx, ab);
      checkRun($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rank_order_encoder.md
# rank_order_encoder

Parametrised, multi-channel successor to the single-image rank-order encoder. Pixels are streamed in over a valid/ready port into internal storage, then emitted as AER events in descending-intensity order on a four-phase REQ/ACK link into the SNN input layer. New over the previous generation:
- runtime threshold
- event-count cap (k-winner truncation)
- channel field in the address
- level skipping, so empty intensity levels cost no scan passes

## Interface
Parameters:
- IMAGE_SIZE, 256, pixels per channel
- IMAGE_SIZE_BITS, 8, log2(IMAGE_SIZE)
- PIXEL_W, 8, pixel width in bits
- CHANNELS, 1, channels per image (1..4); TOTAL = CHANNELS*IMAGE_SIZE
- CNT_W, IMAGE_SIZE_BITS+3, width of event counters

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset (RST=0 resets)
- NEW_IMAGE  in  1  single-cycle start pulse; ignored unless IDLE
- THRESHOLD  in  PIXEL_W  minimum emitted value; sampled on accepted NEW_IMAGE
- MAX_EVENTS  in  CNT_W  event cap, 0 = unlimited; sampled on accepted NEW_IMAGE
- PIX_DATA  in  PIXEL_W  streamed pixel
- PIX_VALID  in  1  PIX_DATA valid
- PIX_READY  out  1  high only in LOAD
- INFERENCE_DONE  in  1  abort request
- IMAGE_ENCODED  out  1  one-cycle completion pulse
- BUSY  out  1  high in every state except IDLE
- EVENT_COUNT  out  CNT_W  events emitted for the current image
- AERIN_ADDR  out  IMAGE_SIZE_BITS+2  {channel[1:0], pixel_id}
- AERIN_REQ  out  1  AER request
- AERIN_ACK  in  1  AER acknowledge

## Operation
- States: IDLE, LOAD, SCAN, REQ, RELEASE, DONE.
- IDLE:
  - NEW_IMAGE=1 → LOAD.
  - Latch THRESHOLD and MAX_EVENTS.
  - Clear EVENT_COUNT, load index and running max.
- LOAD:
  - Each PIX_VALID&PIX_READY writes mem[idx] and increments idx.
  - Order is channel-major: channel 0 pixels 0..IMAGE_SIZE-1, then channel 1, and so on.
  - Running max is tracked during LOAD.
  - After TOTAL beats, the next state depends on the running max:
    - max ≥ THRESHOLD → SCAN, with level=max and idx=0.
    - otherwise → DONE with zero events.
- SCAN: one pixel compared per cycle (v = mem[idx]).
  - v==level → latch AERIN_ADDR={idx/IMAGE_SIZE, idx%IMAGE_SIZE} → REQ.
  - THRESHOLD ≤ v < level and v > next_max → next_max=v, next_valid=1.
  - At idx=TOTAL-1 (after any emission for that pixel):
    - next_valid=1 → level=next_max, clear next_max/next_valid, idx=0.
    - next_valid=0 → DONE.
- Ordering result: events are strictly descending by value. Ties go in ascending channel, then ascending pixel_id.
- REQ:
  - AERIN_REQ=1, AERIN_ADDR held stable.
  - On AERIN_ACK=1: drop REQ, increment EVENT_COUNT → RELEASE.
- RELEASE:
  - Wait for AERIN_ACK=0, then evaluate in this priority:
    - EVENT_COUNT==MAX_EVENTS (with MAX_EVENTS≠0) or abort pending → DONE.
    - Otherwise resume SCAN at the next pixel index (same end-of-pass rules).
- Abort:
  - INFERENCE_DONE=1 seen in LOAD or SCAN → DONE next cycle.
  - Seen in REQ/RELEASE → set abort_pending; the handshake always completes first. REQ is never withdrawn before ACK.
- DONE: IMAGE_ENCODED=1 for one cycle → IDLE. EVENT_COUNT holds until the next accepted NEW_IMAGE.
- Reset:
  - RST=0 in any state → IDLE immediately.
  - Outputs are 0: PIX_READY, AERIN_REQ, AERIN_ADDR, IMAGE_ENCODED, BUSY, EVENT_COUNT.
  - Memory contents are don't-care.

## Timing
- Accepted NEW_IMAGE at edge n → PIX_READY=1 from cycle n+1.
- The last load beat drops PIX_READY in the next cycle.
- SCAN hit at cycle k → AERIN_REQ=1 at k+1.
- AERIN_ACK rise sampled at edge m → AERIN_REQ=0 at m+1.
- AERIN_ACK low sampled → SCAN, or DONE, the next cycle.
- DONE → IMAGE_ENCODED high exactly one cycle, one cycle after the last ACK low (or after the abort/empty decision).
- Scan cost: TOTAL cycles per distinct value ≥ THRESHOLD, plus 2 cycles + handshake time per event.
- All outputs are registered. ACK and INFERENCE_DONE are synchronous inputs.

## Test plan
- Ordering: IMAGE_SIZE=4, CHANNELS=1, pixels {10,200,10,0}, THRESHOLD=1, MAX_EVENTS=0 → ADDR 1,0,2. Pixel 3 never emitted. EVENT_COUNT=3, one IMAGE_ENCODED pulse.
- Cap: same image, MAX_EVENTS=2 → ADDR 1,0 only. IMAGE_ENCODED after the second ACK falls. EVENT_COUNT=2.
- Channels: CHANNELS=2, IMAGE_SIZE=4, ch0={5,0,0,0}, ch1={0,9,5,0}, THRESHOLD=1 → ADDR {01,1},{00,0},{01,2}.
- Empty image: all pixels below THRESHOLD=50 → no REQ. IMAGE_ENCODED one cycle after the last load beat. EVENT_COUNT=0.
- Abort: INFERENCE_DONE pulsed while AERIN_REQ=1 → REQ stays high until ACK, handshake completes, no further REQ, IMAGE_ENCODED pulses. A NEW_IMAGE pulse while BUSY is ignored.
- Reset mid-handshake: RST=0 during REQ → AERIN_REQ=0, BUSY=0, EVENT_COUNT=0 immediately. After release, a fresh image encodes correctly. The 256-pixel reference digit with random-delay ACK yields a strictly non-increasing value sequence.
